fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
// - IF stage ahead of the decode stage register. Owns the PC and issues in-order requests to instruction memory.
// - Buffers returned {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
// - Handles redirects from execute (taken branch/jump): squashes the FIFO and drops in-flight responses.
// PARAMETERS
// - DPW       32  datapath / PC / instruction width
// - DEPTH      4  fetch FIFO entries (power of 2, >=2)
// - MAX_OUTST  2  max outstanding imem requests (<= DEPTH)
// - RESET_PC   0  PC after reset (word aligned)
// PORTS
// - clk            in   1    clock, all state on rising edge
// - rst_n          in   1    asynchronous active-low reset
// - stallF         in   1    1 = issue no new imem request this cycle
// - pcsrcE         in   1    redirect strobe from execute
// - pctargetE      in   DPW  redirect target; bits [1:0] ignored (treated as 0)
// - imem_req       out  1    request valid
// - imem_addr      out  DPW  request address (= pc_q)
// - imem_gnt       in   1    request accepted this cycle (only meaningful with imem_req)
// - imem_rvalid    in   1    in-order response valid, >=1 cycle after grant
// - imem_rdata     in   DPW  response instruction
// - fetch_valid    out  1    FIFO head valid to decode
// - decode_ready   in   1    decode consumes head (0 = stallD)
// - fetch_instr    out  DPW  head instruction
// - fetch_pc       out  DPW  head PC
// - fetch_pcplus4  out  DPW  fetch_pc + 4, mod 2^DPW
// BEHAVIOUR
// - Reset (async, any time): pc_q=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; PC-tag queue empty.
//   imem_req=0, fetch_valid=0. Responses arriving after reset are ignored (outstanding=0).
// - Issue: imem_req = !rst && !stallF && !pcsrcE && outstanding<MAX_OUTST && (fifo_count+outstanding)<DEPTH.
//   The credit rule guarantees every live response has a FIFO slot.
// - On imem_req&&imem_gnt: push pc_q into the tag queue, pc_q += 4 (wraps), outstanding++.
//   A non-granted request holds imem_addr stable.
// - On imem_rvalid: pop the tag queue, outstanding--.
//   If drop_cnt>0: drop_cnt--, discard the data. Else push {tag_pc, imem_rdata} into the FIFO.
// - imem_rvalid with outstanding==0 is a protocol error: ignore it, assertion fires.
// - Output: fetch_valid = !fifo_empty && !pcsrcE. Pop when fetch_valid && decode_ready.
//   Combinational from the FIFO head: 0-cycle output latency. Minimum request-to-fetch_valid is 1 cycle after rvalid.
// - Push and pop in the same cycle are allowed at any occupancy, including full; the count is unchanged.
// - Redirect (pcsrcE=1) wins over all else that cycle:
//   - pc_q <= {pctargetE[DPW-1:2],2'b00}; FIFO cleared; no issue; no pop.
//   - drop_cnt <= outstanding - (imem_rvalid?1:0) + (imem_rvalid&&drop_cnt>0 ? 0 : 0).
//     Equivalently, every request still in flight after this cycle is dropped.
//   - A response arriving in the redirect cycle is discarded.
//   - Back-to-back redirects: the latest target wins; drop_cnt recomputes from outstanding.
// - stallF blocks issue only. Responses are still accepted and decode may still pop.
// - FSM: none beyond counters. States are implied by (outstanding, drop_cnt, fifo_count).
//   Invariants: drop_cnt <= outstanding; fifo_count+outstanding <= DEPTH.
// TESTING
// - Zero-wait memory (gnt=1, rvalid 1 cycle later), decode_ready=1, release reset ->
//   imem_addr 0x0,0x4,0x8...; fetch_pc=0x0 valid 2 cycles after reset release, then one per cycle, in order.
// - decode_ready=0 for 10 cycles -> exactly DEPTH(4) entries fetched, imem_req=0 after.
//   Resume -> PCs 0x0..0xC drained in order, no loss or duplicate.
// - Redirect to 0x100 with 2 requests outstanding (rvalid latency 3) -> both responses discarded;
//   next fetch_pc=0x100, fetch_pcplus4=0x104.
// - pcsrcE coincident with imem_rvalid and FIFO full -> FIFO empty next cycle, drop_cnt=outstanding-1, no stale instr reaches decode.
// - stallF=1 for 5 cycles with FIFO holding 3 -> imem_req=0 throughout, 3 entries drain, fetch_valid=0 after.
// - RESET_PC=0xFFFFFFFC -> imem_addr 0xFFFFFFFC then 0x00000000; fetch_pcplus4=0x0. Assert rst_n mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and buffers
// returned {pc, instr} pairs for decode. A redirect squashes the buffer and drops in-flight responses.
module fetch_prefetch_unit #(
  parameter int             DPW       = 32,
  parameter int             DEPTH     = 4,
  parameter int             MAX_OUTST = 2,
  parameter logic [DPW-1:0] RESET_PC  = {DPW{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stallF,
  input  logic           pcsrcE,
  input  logic [DPW-1:0] pctargetE,
  output logic           imem_req,
  output logic [DPW-1:0] imem_addr,
  input  logic           imem_gnt,
  input  logic           imem_rvalid,
  input  logic [DPW-1:0] imem_rdata,
  output logic           fetch_valid,
  input  logic           decode_ready,
  output logic [DPW-1:0] fetch_instr,
  output logic [DPW-1:0] fetch_pc,
  output logic [DPW-1:0] fetch_pcplus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [DPW-1:0] pc_r;
  logic [DPW-1:0] tagPc_r     [DEPTH];
  logic [DPW-1:0] fifoPc_r    [DEPTH];
  logic [DPW-1:0] fifoInstr_r [DEPTH];
  logic [AW-1:0]  tagWr_r, tagRd_r, fifoWr_r, fifoRd_r;
  logic [CW-1:0]  fifoCount_r, outst_r, dropCnt_r;

  logic [CW:0]    credit_s;
  logic           issue_s, grant_s, respOk_s, respPush_s, valid_s, pop_s;
  logic           unusedTargetBits_s;

  // Issue credit, response acceptance and head handshake decode
  always_comb begin
    credit_s   = {1'b0, fifoCount_r} + {1'b0, outst_r};
    issue_s    = 1'b0;
    respOk_s   = 1'b0;
    respPush_s = 1'b0;
    valid_s    = 1'b0;
    if (rst_n && !stallF && !pcsrcE && (outst_r < MAXO_C) && (credit_s < DEPTH_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    // a response with nothing outstanding is a protocol error and is ignored
    if (imem_rvalid && (outst_r != {CW{1'b0}})) begin
      respOk_s = 1'b1;
    end else begin
      respOk_s = 1'b0;
    end
    if (respOk_s && (dropCnt_r == {CW{1'b0}}) && !pcsrcE) begin
      respPush_s = 1'b1;
    end else begin
      respPush_s = 1'b0;
    end
    if ((fifoCount_r != {CW{1'b0}}) && !pcsrcE) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    grant_s = issue_s && imem_gnt;
    pop_s   = valid_s && decode_ready;
  end

  assign unusedTargetBits_s = ^pctargetE[1:0];

  assign imem_req      = issue_s;
  assign imem_addr     = pc_r;
  assign fetch_valid   = valid_s;
  assign fetch_pc      = valid_s ? fifoPc_r[fifoRd_r]    : {DPW{1'b0}};
  assign fetch_instr   = valid_s ? fifoInstr_r[fifoRd_r] : {DPW{1'b0}};
  assign fetch_pcplus4 = valid_s ? (fifoPc_r[fifoRd_r] + DPW'(3'd4)) : {DPW{1'b0}};

  // PC register and in-order tag queue of issued PCs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      tagWr_r <= {AW{1'b0}};
      tagRd_r <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tagPc_r[i] <= {DPW{1'b0}};
      end
    end else begin
      if (pcsrcE) begin
        pc_r <= {pctargetE[DPW-1:2], 2'b00};
      end else if (grant_s) begin
        pc_r <= pc_r + DPW'(3'd4);
      end
      if (grant_s) begin
        tagPc_r[tagWr_r] <= pc_r;
        tagWr_r          <= tagWr_r + AW'(1'b1);
      end
      // tags are popped even for dropped responses so they stay aligned
      if (respOk_s) begin
        tagRd_r <= tagRd_r + AW'(1'b1);
      end
    end
  end

  // Outstanding-request and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r   <= {CW{1'b0}};
      dropCnt_r <= {CW{1'b0}};
    end else begin
      case ({grant_s, respOk_s})
        2'b10:   outst_r <= outst_r + CW'(1'b1);
        2'b01:   outst_r <= outst_r - CW'(1'b1);
        default: outst_r <= outst_r;
      endcase
      if (pcsrcE) begin
        dropCnt_r <= respOk_s ? (outst_r - CW'(1'b1)) : outst_r;
      end else if (respOk_s && (dropCnt_r != {CW{1'b0}})) begin
        dropCnt_r <= dropCnt_r - CW'(1'b1);
      end
    end
  end

  // Fetch FIFO storage and occupancy; a redirect empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifoWr_r    <= {AW{1'b0}};
      fifoRd_r    <= {AW{1'b0}};
      fifoCount_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifoPc_r[i]    <= {DPW{1'b0}};
        fifoInstr_r[i] <= {DPW{1'b0}};
      end
    end else if (pcsrcE) begin
      fifoWr_r    <= {AW{1'b0}};
      fifoRd_r    <= {AW{1'b0}};
      fifoCount_r <= {CW{1'b0}};
    end else begin
      if (respPush_s) begin
        fifoPc_r[fifoWr_r]    <= tagPc_r[tagRd_r];
        fifoInstr_r[fifoWr_r] <= imem_rdata;
        fifoWr_r              <= fifoWr_r + AW'(1'b1);
      end
      if (pop_s) begin
        fifoRd_r <= fifoRd_r + AW'(1'b1);
      end
      case ({respPush_s, pop_s})
        2'b10:   fifoCount_r <= fifoCount_r + CW'(1'b1);
        2'b01:   fifoCount_r <= fifoCount_r - CW'(1'b1);
        default: fifoCount_r <= fifoCount_r;
      endcase
    end
  end

  fetch_prefetch_checker #(
    .CW        (CW),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .outst       (outst_r),
    .dropCnt     (dropCnt_r),
    .fifoCount   (fifoCount_r)
  );

endmodule

// Protocol and invariant checks for the fetch unit counters.
module fetch_prefetch_checker #(
  parameter int CW        = 3,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          imem_rvalid,
  input logic [CW-1:0] outst,
  input logic [CW-1:0] dropCnt,
  input logic [CW-1:0] fifoCount
);

  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

  rvalidWithoutRequest: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outst == {CW{1'b0}})));

  dropWithinOutstanding: assert property (@(posedge clk) disable iff (!rst_n)
    dropCnt <= outst);

  creditWithinDepth: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, fifoCount} + {1'b0, outst}) <= DEPTH_C);

  outstandingBounded: assert property (@(posedge clk) disable iff (!rst_n)
    outst <= MAXO_C);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a latency-configurable imem model feeds the DUT
// and every decode pop is checked against the expected {pc, instr} queue.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0, pcsrcE = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, decode_ready = 1'b0;
  logic [31:0] pctargetE = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, fetch_instr, fetch_pc, fetch_pcplus4;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DPW(32), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .pcsrcE(pcsrcE), .pctargetE(pctargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .decode_ready(decode_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_pcplus4(fetch_pcplus4));

  fetch_prefetch_unit #(.DPW(32), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .pcsrcE(pcsrcE), .pctargetE(pctargetE),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .fetch_valid(valid2), .decode_ready(decode_ready),
    .fetch_instr(instr2), .fetch_pc(pc2), .fetch_pcplus4(pc4_2));

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  req_t pend[$];
  ent_t expq[$];

  int nTests = 0, nFail = 0, cyc = 0, lat = 1, popCount = 0;
  bit stallQ, pcsrcQ, readyQ, gntQ, wrapChk;
  logic [31:0] targetQ = 32'h0, pcModel = 32'h0;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h5EED_0013 ^ {a[15:0], a[31:16]};
  endfunction

  // one clock cycle: drive at negedge, check and advance the model 1 ns later
  task automatic step();
    bit deliver, expReq, expValid;
    req_t r;
    @(negedge clk);
    stallF = stallQ; pcsrcE = pcsrcQ; pctargetE = targetQ; decode_ready = readyQ; imem_gnt = gntQ;
    deliver = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = deliver;
    imem_rdata = deliver ? instrOf(pend[0].addr) : 32'h0;
    #1;
    expReq   = !stallQ && !pcsrcQ && (pend.size() < MAXO) && ((expq.size() + pend.size()) < DEPTH);
    expValid = (expq.size() != 0) && !pcsrcQ;
    nTests++;
    if (imem_req !== expReq) begin nFail++; $display("FAIL imem_req cyc%0d: got %b expected %b", cyc, imem_req, expReq); end
    nTests++;
    if (fetch_valid !== expValid) begin nFail++; $display("FAIL fetch_valid cyc%0d: got %b expected %b", cyc, fetch_valid, expValid); end
    if (expReq) begin
      nTests++;
      if (imem_addr !== pcModel) begin nFail++; $display("FAIL imem_addr cyc%0d: got %h expected %h", cyc, imem_addr, pcModel); end
    end
    if (expValid && fetch_valid) begin
      nTests++;
      if (fetch_pc !== expq[0].pc || fetch_instr !== expq[0].instr || fetch_pcplus4 !== expq[0].pc + 32'd4) begin
        nFail++;
        $display("FAIL head cyc%0d: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h", cyc,
                 fetch_pc, fetch_instr, fetch_pcplus4, expq[0].pc, expq[0].instr, expq[0].pc + 32'd4);
      end
    end
    if (wrapChk) begin
      nTests++;
      if (req2 !== imem_req || valid2 !== fetch_valid || (imem_req && addr2 !== imem_addr - 32'd4) ||
          (fetch_valid && (pc2 !== fetch_pc - 32'd4 || pc4_2 !== fetch_pc))) begin
        nFail++;
        $display("FAIL wrap_mirror cyc%0d: got req %b addr %h valid %b pc %h pc4 %h expected addr %h pc %h pc4 %h",
                 cyc, req2, addr2, valid2, pc2, pc4_2, imem_addr - 32'd4, fetch_pc - 32'd4, fetch_pc);
      end
    end
    if (expValid && readyQ) begin void'(expq.pop_front()); popCount++; end
    if (deliver) begin
      r = pend.pop_front();
      if (!r.stale && !pcsrcQ) expq.push_back('{pc: r.addr, instr: instrOf(r.addr)});
    end
    if (pcsrcQ) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      pcModel = {targetQ[31:2], 2'b00};
    end else if (expReq && gntQ) begin
      pend.push_back('{addr: pcModel, due: cyc + lat, stale: 1'b0});
      pcModel = pcModel + 32'd4;
    end
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 1'b0; pcsrcE = 1'b0; stallF = 1'b0;
    pend.delete(); expq.delete();
    pcModel = 32'h0; stallQ = 1'b0; pcsrcQ = 1'b0; readyQ = 1'b1; gntQ = 1'b1; lat = 1; wrapChk = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk); rst_n = 1'b0; #1;
    nTests++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== 32'h0 || req2 !== 1'b0 || addr2 !== 32'hFFFF_FFFC) begin
      nFail++; $display("FAIL reset_state: got req %b valid %b addr %h addr2 %h expected 0 0 0 fffffffc", imem_req, fetch_valid, imem_addr, addr2);
    end
  endtask

  task automatic test_stream();
    doReset();
    step();
    nTests++;
    if (imem_addr !== 32'h0) begin nFail++; $display("FAIL stream_first_addr: got %h expected 00000000", imem_addr); end
    step();
    step();
    nTests++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin nFail++; $display("FAIL stream_latency: got valid %b pc %h expected 1 00000000", fetch_valid, fetch_pc); end
    repeat (12) step();
  endtask

  task automatic test_backpressure();
    doReset();
    readyQ = 1'b0;
    repeat (10) step();
    nTests++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b1) begin nFail++; $display("FAIL bp_full: got req %b valid %b expected 0 1", imem_req, fetch_valid); end
    readyQ = 1'b1;
    step();
    nTests++;
    if (fetch_pc !== 32'h0) begin nFail++; $display("FAIL bp_resume_head: got %h expected 00000000", fetch_pc); end
    repeat (8) step();
  endtask

  task automatic waitValid(input logic [31:0] pcExp, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = fetch_valid;
    end
    nTests++;
    if (!seen || fetch_pc !== pcExp || fetch_pcplus4 !== pcExp + 32'd4) begin
      nFail++; $display("FAIL %s: got valid %b pc %h pc4 %h expected pc %h pc4 %h", nm, seen, fetch_pc, fetch_pcplus4, pcExp, pcExp + 32'd4);
    end
  endtask

  task automatic test_redirect();
    doReset();
    lat = 3;
    step(); step();
    pcsrcQ = 1'b1; targetQ = 32'h0000_0103;
    step();
    pcsrcQ = 1'b0;
    waitValid(32'h0000_0100, "redirect_target");
    repeat (3) step();
    pcsrcQ = 1'b1; targetQ = 32'h0000_0300;
    step();
    targetQ = 32'h0000_0404;
    step();
    pcsrcQ = 1'b0;
    waitValid(32'h0000_0404, "back_to_back_redirect");
    repeat (4) step();
  endtask

  task automatic test_redirect_full();
    bit hit = 1'b0;
    doReset();
    lat = 3; readyQ = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (pend.size() == 2 && pend[0].due <= cyc && expq.size() >= 2) hit = 1'b1;
      else step();
    end
    nTests++;
    if (!hit) begin nFail++; $display("FAIL redirect_full_setup: got no full+rvalid cycle expected one"); end
    pcsrcQ = 1'b1; targetQ = 32'h0000_0200;
    step();
    pcsrcQ = 1'b0; readyQ = 1'b1;
    step();
    nTests++;
    if (fetch_valid !== 1'b0) begin nFail++; $display("FAIL redirect_full_flush: got valid %b expected 0", fetch_valid); end
    waitValid(32'h0000_0200, "redirect_full_target");
    repeat (4) step();
  endtask

  task automatic test_stallf();
    int pops;
    doReset();
    readyQ = 1'b0;
    for (int i = 0; i < 10 && (pend.size() + expq.size()) < 3; i++) step();
    stallQ = 1'b1; readyQ = 1'b1;
    pops = popCount;
    repeat (5) step();
    nTests++;
    if (popCount - pops != 3 || fetch_valid !== 1'b0) begin
      nFail++; $display("FAIL stallf_drain: got %0d pops valid %b expected 3 pops valid 0", popCount - pops, fetch_valid);
    end
    stallQ = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_gnt_wait();
    logic [31:0] held;
    doReset();
    repeat (3) step();
    gntQ = 1'b0;
    step();
    held = imem_addr;
    repeat (3) step();
    nTests++;
    if (imem_addr !== held || imem_req !== 1'b1) begin nFail++; $display("FAIL gnt_hold: got req %b addr %h expected 1 %h", imem_req, imem_addr, held); end
    gntQ = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_wrap();
    doReset();
    wrapChk = 1'b1;
    step();
    nTests++;
    if (addr2 !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL wrap_addr0: got %h expected fffffffc", addr2); end
    step();
    nTests++;
    if (addr2 !== 32'h0000_0000) begin nFail++; $display("FAIL wrap_addr1: got %h expected 00000000", addr2); end
    step();
    nTests++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0) begin
      nFail++; $display("FAIL wrap_head: got valid %b pc %h pc4 %h expected 1 fffffffc 00000000", valid2, pc2, pc4_2);
    end
    repeat (4) step();
    // asynchronous reset in the middle of a burst
    @(negedge clk); #3 rst_n = 1'b0; #1;
    nTests++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_pc !== 32'h0 ||
        fetch_instr !== 32'h0 || fetch_pcplus4 !== 32'h0 || req2 !== 1'b0 || valid2 !== 1'b0) begin
      nFail++; $display("FAIL async_reset: got req %b valid %b addr %h pc %h instr %h pc4 %h expected all 0",
                        imem_req, fetch_valid, imem_addr, fetch_pc, fetch_instr, fetch_pcplus4);
    end
    doReset();
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_stallf();
    test_gnt_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
